fetch_unit: RTL and testbench

- Multicycle instruction-fetch and PC-sequencing stage that sits directly upstream of the main decoder.
- Holds the PC and issues requests to a variable-latency instruction memory. It latches the returned word into an instruction register whose bits [6:0] drive the decoder's opcode input.
- On retire it consumes the decoder's Jump/JumpR/Branch outputs, plus the datapath's compare and ALU results, to select the next PC.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: multicycle instruction fetch and PC sequencing stage.
// Holds the PC, fetches from a variable-latency instruction memory into the
// instruction register, and selects the next PC when the datapath retires.
// Optional build macro FETCH_TIMEOUT_EN adds a fetch-timeout fault.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | request outstanding at pc, waiting for imem_ready
// S_EXEC  | instr valid, waiting for retire (stall holds)
// S_TRAP  | fault latched, everything frozen until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        stall,
  input  logic        Jump,
  input  logic        JumpR,
  input  logic        Branch,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam int         TO_W           = $clog2(TIMEOUT_CYCLES + 1);
`endif

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic        valid_nxt;
  logic        req_nxt;
  logic        fault_nxt;
  logic [1:0]  cause_nxt;
  logic [31:0] next_pc;
  logic        accept;

  assign imem_addr = pc;
  assign opcode    = instr[6:0];
  assign pc_plus4  = pc + 32'd4;

  // ready only counts while a request is actually outstanding
  assign accept = (state == S_FETCH) && imem_req && imem_ready;

`ifdef FETCH_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_expired;

  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES));

  // count FETCH cycles without a capture; cleared whenever FETCH is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if ((state == S_FETCH) && !accept && !to_expired) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`endif

  // next-PC selection: JumpR > Jump / taken Branch > sequential
  always_comb begin
    next_pc = pc_plus4;
    if (JumpR) begin
      next_pc = alu_result & 32'hFFFF_FFFE;
    end else if (Jump || (Branch && branch_taken)) begin
      next_pc = pc + imm_ext;
    end
  end

  // next-state and next-register values
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    valid_nxt = instr_valid;
    req_nxt   = imem_req;
    fault_nxt = fault;
    cause_nxt = fault_cause;
    case (state)
      S_FETCH: begin
        req_nxt = 1'b1;
        if (accept) begin
          instr_nxt = imem_rdata;
          valid_nxt = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = S_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (to_expired) begin
          req_nxt   = 1'b0;
          fault_nxt = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
          state_nxt = S_TRAP;
        end
`endif
      end
      S_EXEC: begin
        req_nxt = 1'b0;
        if (retire && !stall) begin
          valid_nxt = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            fault_nxt = 1'b1;
            cause_nxt = CAUSE_MISALIGN;
            state_nxt = S_TRAP;
          end else begin
            pc_nxt    = next_pc;
            req_nxt   = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_TRAP: begin
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_TRAP;
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      imem_req    <= req_nxt;
      fault       <= fault_nxt;
      fault_cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit with a transaction-level PC model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        stall;
  logic        Jump;
  logic        JumpR;
  logic        Branch;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        fault;
  logic [1:0]  fault_cause;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(32'h13), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .retire(retire),
    .stall(stall), .Jump(Jump), .JumpR(JumpR), .Branch(Branch),
    .branch_taken(branch_taken), .imm_ext(imm_ext), .alu_result(alu_result),
    .fault(fault), .fault_cause(fault_cause));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    retire = 0; stall = 0; Jump = 0; JumpR = 0; Branch = 0; branch_taken = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instr, 32'h13);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_cause"}, fault_cause, 0);
  endtask

  // wait cycles with noise on ignored inputs, then deliver one word
  task automatic fetch(input int waits, input logic [31:0] word);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 0; imem_rdata = $urandom;
      retire = 1'($urandom_range(0, 1)); stall = 1'($urandom_range(0, 1));
      Jump = 1'($urandom_range(0, 1)); JumpR = 1'($urandom_range(0, 1));
      Branch = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
      alu_result = $urandom; imm_ext = $urandom;
      tick();
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", instr_valid, 0);
      chk("wait_instr", instr, exp_instr);
    end
    clear_ctl();
    imem_ready = 1; imem_rdata = word;
    tick();
    imem_ready = 0; imem_rdata = $urandom;
    exp_instr = word;
    chk("cap_valid", instr_valid, 1);
    chk("cap_instr", instr, word);
    chk("cap_opcode", opcode, {25'b0, word[6:0]});
    chk("cap_req", imem_req, 0);
    chk("cap_pc", pc, exp_pc);
    chk("cap_pc4", pc_plus4, exp_pc + 32'd4);
  endtask

  task automatic do_retire(input int stalls, input logic j, input logic jr, input logic br,
                           input logic tk, input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] tgt;
    for (int i = 0; i < stalls; i++) begin
      retire = 1'($urandom_range(0, 1)); stall = 1;
      Jump = j; JumpR = jr; Branch = br; branch_taken = tk; imm_ext = imm; alu_result = alu;
      tick();
      chk("stall_pc", pc, exp_pc);
      chk("stall_instr", instr, exp_instr);
      chk("stall_valid", instr_valid, 1);
      chk("stall_req", imem_req, 0);
    end
    retire = 1; stall = 0;
    Jump = j; JumpR = jr; Branch = br; branch_taken = tk; imm_ext = imm; alu_result = alu;
    tick();
    clear_ctl();
    if (jr) tgt = {alu[31:1], 1'b0};
    else if (j || (br && tk)) tgt = exp_pc + imm;
    else tgt = exp_pc + 32'd4;
    chk("ret_valid", instr_valid, 0);
    if (tgt[1:0] != 2'b00) begin
      chk("trap_fault", fault, 1);
      chk("trap_cause", fault_cause, 2'b01);
      chk("trap_req", imem_req, 0);
      chk("trap_pc", pc, exp_pc);
    end else begin
      exp_pc = tgt;
      chk("ret_pc", pc, tgt);
      chk("ret_req", imem_req, 1);
      chk("ret_fault", fault, 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    tick();
    rst_n = 1;
    exp_pc = 32'h0;
    exp_instr = 32'h13;
    tick();
  endtask

  initial begin
    rst_n = 0; imem_ready = 0; imem_rdata = 0; imm_ext = 0; alu_result = 0;
    clear_ctl();
    exp_pc = 32'h0; exp_instr = 32'h13;
    tick(); tick();
    check_reset_vals("rst");
    rst_n = 1;
    imem_ready = 1;   // ignored: no request outstanding yet
    tick();
    imem_ready = 0;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", instr_valid, 0);

    fetch(0, 32'h0050_0093);
    do_retire(0, 0, 0, 0, 0, $urandom, $urandom);        // pc 4
    fetch(5, 32'h0000_0013);
    do_retire(0, 1, 0, 0, 0, 32'h0000_00FC, 0);          // pc 0x100
    fetch(0, $urandom);
    do_retire(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 0);          // 0xF8
    fetch(1, $urandom);
    do_retire(0, 1, 0, 0, 0, 32'h8, 0);                  // 0x100
    fetch(0, $urandom);
    do_retire(0, 0, 0, 1, 0, 32'hFFFF_FFF8, 0);          // 0x104
    fetch(2, $urandom);
    do_retire(1, 1, 1, 0, 0, 32'h40, 32'h0000_0201);     // 0x200
    fetch(0, $urandom);
    do_retire(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFD);          // 0xFFFFFFFC
    fetch(0, $urandom);
    do_retire(0, 0, 0, 0, 0, 0, 0);                      // wraps to 0

    for (int n = 0; n < 30; n++) begin
      int signed off;
      off = ($urandom_range(0, 255) - 128) * 4;
      fetch($urandom_range(0, 3), $urandom);
      do_retire($urandom_range(0, 2), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'(off),
                ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1)));
    end

    fetch(0, $urandom);
    do_retire(3, 0, 1, 0, 0, 0, 32'h0000_0202);          // misaligned -> trap
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      retire = 1'($urandom_range(0, 1)); JumpR = 1'($urandom_range(0, 1));
      tick();
      chk("frz_req", imem_req, 0);
      chk("frz_valid", instr_valid, 0);
      chk("frz_fault", fault, 1);
      chk("frz_cause", fault_cause, 2'b01);
      chk("frz_pc", pc, exp_pc);
      chk("frz_instr", instr, exp_instr);
    end
    imem_ready = 0; clear_ctl();

    do_reset();
    chk("rel_req", imem_req, 1);
    chk("rel_fault", fault, 0);
    fetch(0, $urandom);
    do_retire(0, 0, 0, 0, 0, 0, 0);                      // pc 4, back in FETCH
    imem_ready = 0;
    tick();
    chk("mid_req", imem_req, 1);
    rst_n = 0;
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check_reset_vals("async");
    tick();
    check_reset_vals("hold");
    rst_n = 1;
    tick();
    exp_pc = 32'h0; exp_instr = 32'h13;
    chk("post_req", imem_req, 1);
    chk("post_valid", instr_valid, 0);
    chk("post_instr", instr, 32'h13);
    chk("post_pc", pc, 32'h0);
    imem_ready = 0;
    fetch(1, 32'h0000_6F13);
    do_retire(0, 1, 0, 0, 0, 32'h0000_0002, 0);          // Jump to pc+2 -> trap

`ifdef FETCH_TIMEOUT_EN
    rst_n = 0; imem_ready = 0; #1;
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_nofault", fault, 0);
    end
    tick();
    chk("to_fault", fault, 1);
    chk("to_cause", fault_cause, 2'b10);
    chk("to_req", imem_req, 0);
    rst_n = 0; #1;
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) tick();
    imem_ready = 1; imem_rdata = 32'h0000_0113;
    tick();
    imem_ready = 0;
    chk("to_edge_valid", instr_valid, 1);
    chk("to_edge_fault", fault, 0);
    chk("to_edge_instr", instr, 32'h0000_0113);
`else
    do_reset();
    for (int i = 0; i < 40; i++) tick();
    chk("nto_fault", fault, 0);
    chk("nto_req", imem_req, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
